mapper_flash_banked: RTL

Parametrised ASCII-style cartridge bank mapper with an integrated AMD-compatible flash command engine, the successor to the fixed-layout banked mappers in the slot subsystem. It maps the 0x4000–0xBFFF CPU window onto a flash image in SDRAM via 8 KB or 16 KB bank registers. It also interprets unlock/program/erase/autoselect command sequences, so cartridges can be written at run time. It sits between the slot decoder (`cs`) and the memory arbiter.

---
 rtl/msx_slot_pkg.sv | 29 ++
 rtl/flash_cmd_fsm.sv | 105 ++++++++++
 rtl/mapper_flash_banked.sv | 108 ++++++++++
 3 files changed

// File: rtl/msx_slot_pkg.sv
// Shared definitions for the slot subsystem mappers: flash FSM states,
// AMD-style command bytes and command offsets.
package msx_slot_pkg;

  typedef enum logic [3:0] {
    FL_READ    = 4'd0,
    FL_UNL1    = 4'd1,
    FL_UNL2    = 4'd2,
    FL_PROG    = 4'd3,
    FL_ERS1    = 4'd4,
    FL_ERS2    = 4'd5,
    FL_ERS3    = 4'd6,
    FL_BUSY    = 4'd7,
    FL_AUTOSEL = 4'd8
  } flash_state_t;

  localparam logic [7:0] FL_CMD_AA = 8'hAA;
  localparam logic [7:0] FL_CMD_55 = 8'h55;
  localparam logic [7:0] FL_CMD_A0 = 8'hA0;
  localparam logic [7:0] FL_CMD_80 = 8'h80;
  localparam logic [7:0] FL_CMD_90 = 8'h90;
  localparam logic [7:0] FL_CMD_10 = 8'h10;
  localparam logic [7:0] FL_CMD_30 = 8'h30;
  localparam logic [7:0] FL_CMD_F0 = 8'hF0;

  localparam logic [11:0] FL_ADDR_555 = 12'h555;
  localparam logic [11:0] FL_ADDR_2AA = 12'h2AA;

endpackage

// File: rtl/flash_cmd_fsm.sv
// AMD-compatible flash command engine and erase handshake.
// Ports: clk/reset; wr/rd are one-cycle write/read events in the mapped
// flash window; data/addr are the CPU data and mapped flash address;
// erase_done from the arbiter. Outputs: current state, program strobe
// mem_we, erase_req/erase_all/erase_addr, and the busy toggle bit.
module flash_cmd_fsm
  import msx_slot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [7:0]            data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  erase_done,
  output flash_state_t          state,
  output logic                  mem_we,
  output logic                  erase_req,
  output logic                  erase_all,
  output logic [ADDR_WIDTH-1:0] erase_addr,
  output logic                  toggle
);

  flash_state_t          state_n;
  logic                  we_n;
  logic                  all_n;
  logic [ADDR_WIDTH-1:0] eaddr_n;
  logic                  tog_n;
  logic                  at_555;
  logic                  at_2aa;

  assign at_555 = (addr[11:0] == FL_ADDR_555);
  assign at_2aa = (addr[11:0] == FL_ADDR_2AA);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FL_READ;
      mem_we     <= 1'b0;
      erase_req  <= 1'b0;
      erase_all  <= 1'b0;
      erase_addr <= '0;
      toggle     <= 1'b0;
    end else begin
      state      <= state_n;
      mem_we     <= we_n;
      erase_req  <= (state_n == FL_BUSY);
      erase_all  <= all_n;
      erase_addr <= eaddr_n;
      toggle     <= tog_n;
    end
  end

  // Next state: any write that does not continue a known sequence falls back to READ
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    all_n   = erase_all;
    eaddr_n = erase_addr;
    tog_n   = toggle;
    if (state == FL_BUSY) begin
      // erase_done has priority; writes are ignored while busy
      if (erase_done) begin
        state_n = FL_READ;
        all_n   = 1'b0;
      end else if (rd) begin
        tog_n = ~toggle;
      end
    end else if (wr) begin
      state_n = FL_READ;
      if (data != FL_CMD_F0) begin
        case (state)
          FL_READ: if (data == FL_CMD_AA && at_555) state_n = FL_UNL1;
          FL_UNL1: if (data == FL_CMD_55 && at_2aa) state_n = FL_UNL2;
          FL_UNL2: begin
            if (at_555) begin
              if (data == FL_CMD_A0)      state_n = FL_PROG;
              else if (data == FL_CMD_80) state_n = FL_ERS1;
              else if (data == FL_CMD_90) state_n = FL_AUTOSEL;
            end
          end
          FL_PROG: we_n = 1'b1;
          FL_ERS1: if (data == FL_CMD_AA && at_555) state_n = FL_ERS2;
          FL_ERS2: if (data == FL_CMD_55 && at_2aa) state_n = FL_ERS3;
          FL_ERS3: begin
            if (data == FL_CMD_10 && at_555) begin
              state_n = FL_BUSY;
              all_n   = 1'b1;
              tog_n   = 1'b0;
            end else if (data == FL_CMD_30) begin
              state_n = FL_BUSY;
              all_n   = 1'b0;
              eaddr_n = addr & ~ADDR_WIDTH'(32'hFFFF);
              tog_n   = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/mapper_flash_banked.sv
// ASCII-style banked cartridge mapper over a flash image, with an AMD
// command engine for run-time program/erase/autoselect.
// Ports: clk/reset; cpu_addr/din/cpu_mreq/cpu_wr/cpu_rd Z80 bus; cs slot
// select; mem_addr/mem_unmaped/mem_we memory side; erase_req/erase_all/
// erase_addr/erase_done erase handshake; dout/dout_en read override.
module mapper_flash_banked
  import msx_slot_pkg::*;
#(
  parameter int unsigned           BANK_BITS  = 13,
  parameter int unsigned           REG_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH = 25,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [7:0]            MFR_ID     = 8'h01,
  parameter logic [7:0]            DEV_ID     = 8'hA4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            din,
  input  logic                  cpu_mreq,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  input  logic                  cs,
  output logic                  mem_unmaped,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  erase_req,
  output logic                  erase_all,
  output logic [ADDR_WIDTH-1:0] erase_addr,
  input  logic                  erase_done,
  output logic [7:0]            dout,
  output logic                  dout_en
);

  localparam int unsigned IDX_W = 15 - BANK_BITS;
  localparam int unsigned NBANK = 1 << IDX_W;

  logic                 acc;
  logic                 wr_prev;
  logic                 rd_prev;
  logic                 wr_evt;
  logic                 rd_evt;
  logic                 in_win;
  logic                 reg_area;
  logic [15:0]          win_off;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     reg_idx;
  logic [REG_WIDTH-1:0] bank [NBANK];
  flash_state_t         state;
  logic                 toggle;

  assign acc      = cs & cpu_mreq;
  assign wr_evt   = acc & cpu_wr & ~wr_prev;
  assign rd_evt   = acc & cpu_rd & ~rd_prev;
  assign in_win   = (cpu_addr >= 16'h4000) && (cpu_addr < 16'hC000);
  assign reg_area = (cpu_addr[15:12] == 4'h6) || (cpu_addr[15:12] == 4'h7);
  assign win_off  = cpu_addr - 16'h4000;
  assign win_idx  = IDX_W'(win_off >> BANK_BITS);
  assign reg_idx  = cpu_addr[12 -: IDX_W];

  // Edge detectors and bank registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
      for (int unsigned i = 0; i < NBANK; i++) bank[i] <= '0;
    end else begin
      wr_prev <= acc & cpu_wr;
      rd_prev <= acc & cpu_rd;
      if (wr_evt && reg_area) bank[reg_idx] <= REG_WIDTH'(din);
    end
  end

  assign mem_unmaped = cs & ~in_win;
  assign mem_addr    = BASE_ADDR + ADDR_WIDTH'({bank[win_idx], cpu_addr[BANK_BITS-1:0]});

  flash_cmd_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_evt & in_win & ~reg_area),
    .rd         (rd_evt & in_win),
    .data       (din),
    .addr       (mem_addr),
    .erase_done (erase_done),
    .state      (state),
    .mem_we     (mem_we),
    .erase_req  (erase_req),
    .erase_all  (erase_all),
    .erase_addr (erase_addr),
    .toggle     (toggle)
  );

  assign dout_en = acc & cpu_rd & in_win & ((state == FL_BUSY) || (state == FL_AUTOSEL));

  // Read override: busy status toggle or autoselect IDs
  always_comb begin
    dout = 8'h00;
    if (state == FL_BUSY) begin
      dout[6] = toggle;
    end else if (state == FL_AUTOSEL) begin
      if (mem_addr[11:0] == 12'h000)      dout = MFR_ID;
      else if (mem_addr[11:0] == 12'h001) dout = DEV_ID;
    end
  end

endmodule
